ym_phase_gen: RTL and testbench

- Upstream timing stage for the two-phase cell library.
- Divides MCLK into the non-overlapping c1/c2 enable pulses consumed by every sr/latch/counter cell.
- Also provides a slot counter with an end-of-cycle strobe, and a cell-level active-high reset aligned to phase boundaries.
- One instance per chip core; all c1/c2/reset cell inputs in that core are driven from it.

---
 rtl/ym_phase_gen.sv | 90 +++++++++
 tb/tb_ym_phase_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ym_phase_gen.sv
// Two-phase timing generator: divides MCLK into non-overlapping c1/c2 enables,
// tracks the slot index and holds the cell reset for a number of phase pairs.
module ym_phase_gen #(
  parameter int DIV     = 3,
  parameter int SLOTS   = 24,
  parameter int SLOT_W  = 5,
  parameter int RST_CYC = 2
) (
  input  logic              MCLK,
  input  logic              reset_n,
  input  logic              stall,
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              cycle_end,
  output logic              rst_cells
);

  localparam int PH_W = (2 * DIV > 2) ? $clog2(2 * DIV) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [7:0]        RST_LIM   = 8'(RST_CYC);

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              c1_q, c1_d;
  logic              c2_q, c2_d;
  logic              cycleEnd_q, cycleEnd_d;
  logic              rst_q, rst_d;
  logic [7:0]        pairs_q, pairs_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Stalled edges freeze the phase and emit no pulses, so a due pulse slips
  // to the next active edge; only real c2 pulses count toward the reset hold.
  always_comb begin
    phase_d    = phase_q;
    c1_d       = 1'b0;
    c2_d       = 1'b0;
    cycleEnd_d = 1'b0;
    rst_d      = rst_q;
    pairs_d    = pairs_q;
    slot_d     = slot_q;
    if (!stall) begin
      phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      c1_d       = (phase_q == '0);
      c2_d       = (phase_q == PH_HALF);
      cycleEnd_d = c2_d && (slot_q == SLOT_LAST);
      if (c2_d && rst_q && (pairs_q != RST_LIM)) begin
        pairs_d = pairs_q + 8'd1;
      end
      if (c1_d && (pairs_q == RST_LIM)) begin
        rst_d = 1'b0;
      end
    end
    // The slot advances at the edge that ends a c2 pulse.
    if (c2_q) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    if (rst_q) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge MCLK) begin
    if (!reset_n) begin
      phase_q    <= '0;
      c1_q       <= 1'b0;
      c2_q       <= 1'b0;
      cycleEnd_q <= 1'b0;
      rst_q      <= 1'b1;
      pairs_q    <= '0;
      slot_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      cycleEnd_q <= cycleEnd_d;
      rst_q      <= rst_d;
      pairs_q    <= pairs_d;
      slot_q     <= slot_d;
    end
  end

  assign c1        = c1_q;
  assign c2        = c2_q;
  assign slot      = slot_q;
  assign cycle_end = cycleEnd_q;
  assign rst_cells = rst_q;

endmodule

// File: tb/tb_ym_phase_gen.sv
// Directed bench for ym_phase_gen: default DIV=3 instance plus a DIV=1,
// RST_CYC=0 instance with a short slot ring.
module tb_ym_phase_gen;

  logic       MCLK = 1'b0;
  logic       resetN, stall, resetN1, stall1;
  logic       c1, c2, cycleEnd, rstCells;
  logic [4:0] slot;
  logic       c1b, c2b, cycleEndB, rstCellsB;
  logic [1:0] slotB;
  int         total = 0;
  int         bad   = 0;

  ym_phase_gen #(.DIV(3), .SLOTS(24), .SLOT_W(5), .RST_CYC(2)) dut (
    .MCLK(MCLK), .reset_n(resetN), .stall(stall), .c1(c1), .c2(c2),
    .slot(slot), .cycle_end(cycleEnd), .rst_cells(rstCells)
  );

  ym_phase_gen #(.DIV(1), .SLOTS(4), .SLOT_W(2), .RST_CYC(0)) dutFast (
    .MCLK(MCLK), .reset_n(resetN1), .stall(stall1), .c1(c1b), .c2(c2b),
    .slot(slotB), .cycle_end(cycleEndB), .rst_cells(rstCellsB)
  );

  always #5 MCLK = ~MCLK;

  task automatic applyStimulus(input logic rn, input logic st);
    resetN = rn;
    stall  = st;
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Slot after active edge e for DIV=3: first counted c2 is E15, seen at E16.
  function automatic int expSlot(input int e);
    if (e < 16) return 0;
    return ((e - 16) / 6 + 1) % 24;
  endfunction

  task automatic runTimeline(input int from, input int upTo);
    for (int e = from; e <= upTo; e++) begin
      tick();
      checkOutput($sformatf("c1@E%0d", e), int'(c1), int'(e % 6 == 0));
      checkOutput($sformatf("c2@E%0d", e), int'(c2), int'(e % 6 == 3));
      checkOutput($sformatf("rst@E%0d", e), int'(rstCells), int'(e < 12));
      checkOutput($sformatf("slot@E%0d", e), int'(slot), expSlot(e));
      checkOutput($sformatf("cend@E%0d", e), int'(cycleEnd),
                  int'((e % 6 == 3) && (expSlot(e) == 23)));
    end
  endtask

  initial begin
    int held;
    applyStimulus(1'b0, 1'b0);
    resetN1 = 1'b0;
    stall1  = 1'b0;
    repeat (4) tick();
    checkOutput("reset_c1", int'(c1), 0);
    checkOutput("reset_c2", int'(c2), 0);
    checkOutput("reset_slot", int'(slot), 0);
    checkOutput("reset_cend", int'(cycleEnd), 0);
    checkOutput("reset_rst", int'(rstCells), 1);

    // Release and free-run past a full 24-slot cycle.
    applyStimulus(1'b1, 1'b0);
    runTimeline(0, 170);

    // Stall five edges starting where c2 (E171) is due.
    held = expSlot(170);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_c1", int'(c1), 0);
      checkOutput("stall_c2", int'(c2), 0);
      checkOutput("stall_cend", int'(cycleEnd), 0);
      checkOutput("stall_slot", int'(slot), held);
      checkOutput("stall_rst", int'(rstCells), 0);
    end
    applyStimulus(1'b1, 1'b0);
    runTimeline(171, 216);
    checkOutput("mid_c1_slot10", int'(slot), 10);

    // One-cycle reset in the middle of the c1 pulse at slot 10.
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("midrst_c1", int'(c1), 0);
    checkOutput("midrst_c2", int'(c2), 0);
    checkOutput("midrst_slot", int'(slot), 0);
    checkOutput("midrst_rst", int'(rstCells), 1);
    checkOutput("midrst_cend", int'(cycleEnd), 0);
    applyStimulus(1'b1, 1'b0);
    runTimeline(0, 20);

    // Stall held across reset release for three edges.
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("relstall_c1", int'(c1), 0);
      checkOutput("relstall_c2", int'(c2), 0);
      checkOutput("relstall_rst", int'(rstCells), 1);
      checkOutput("relstall_slot", int'(slot), 0);
    end
    applyStimulus(1'b1, 1'b0);
    runTimeline(0, 13);

    // DIV=1, RST_CYC=0, SLOTS=4: alternating pulses, no reset hold.
    resetN1 = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
      checkOutput($sformatf("fast_c1@E%0d", e), int'(c1b), int'(e % 2 == 0));
      checkOutput($sformatf("fast_c2@E%0d", e), int'(c2b), int'(e % 2 == 1));
      checkOutput($sformatf("fast_both@E%0d", e), int'(c1b & c2b), 0);
      checkOutput($sformatf("fast_rst@E%0d", e), int'(rstCellsB), 0);
      checkOutput($sformatf("fast_slot@E%0d", e), int'(slotB), (e / 2) % 4);
      checkOutput($sformatf("fast_cend@E%0d", e), int'(cycleEndB),
                  int'((e % 2 == 1) && ((e / 2) % 4 == 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
